// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register file: response codes and FSM states.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Byte address -> register index, range check and read-only lookup.
module axi_lite_addr_decode #(
  parameter int                ADDR_WIDTH = 32,
  parameter int                DATA_WIDTH = 32,
  parameter int                NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  localparam int               IDX_W      = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      idx,
  output logic                  in_range,
  output logic                  is_ro
);

  localparam int OFF = $clog2(DATA_WIDTH/8);
  localparam logic [ADDR_WIDTH:0] MAP_BYTES = (ADDR_WIDTH+1)'(NUM_REGS*DATA_WIDTH/8);

  assign idx      = addr[OFF +: IDX_W];
  assign in_range = ({1'b0, addr} < MAP_BYTES);
  assign is_ro    = in_range && RO_MASK[idx];

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file with independent write and read FSMs,
// one outstanding transaction per direction.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  output logic [1:0]                     s_bresp,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
  output logic [NUM_REGS-1:0]            wr_pulse,
  output logic [NUM_REGS-1:0]            rd_pulse
);

  localparam int SW    = DATA_WIDTH/8;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs, hw;
  assign hw    = hw_status;
  assign reg_q = regs;

  // ---------------- write channel ----------------
  wr_state_t             w_state, w_nxt;
  logic                  aw_held, w_held, aw_held_nxt, w_held_nxt;
  logic [ADDR_WIDTH-1:0] awaddr_q, waddr;
  logic [DATA_WIDTH-1:0] wdata_q, wdat;
  logic [SW-1:0]         wstrb_q, wstb;
  logic                  aw_hs, w_hs, commit, wr_ok;
  logic                  awready_nxt, wready_nxt, bvalid_nxt;
  resp_t                 bresp_q, bresp_nxt;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_inr, w_ro;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  // Held copies win; otherwise the beat handshaking this cycle is used directly.
  assign waddr = aw_held ? awaddr_q : s_awaddr;
  assign wdat  = w_held ? wdata_q : s_wdata;
  assign wstb  = w_held ? wstrb_q : s_wstrb;
  assign wr_ok = w_inr && !w_ro;
  assign s_bresp = bresp_q;

  axi_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_wdec (
    .addr(waddr), .idx(w_idx), .in_range(w_inr), .is_ro(w_ro)
  );

  always_comb begin
    w_nxt       = w_state;
    aw_held_nxt = aw_held;
    w_held_nxt  = w_held;
    awready_nxt = 1'b0;
    wready_nxt  = 1'b0;
    bvalid_nxt  = s_bvalid;
    bresp_nxt   = bresp_q;
    commit      = 1'b0;
    case (w_state)
      W_IDLE: begin
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          commit      = 1'b1;
          aw_held_nxt = 1'b0;
          w_held_nxt  = 1'b0;
          bvalid_nxt  = 1'b1;
          bresp_nxt   = wr_ok ? RESP_OKAY : RESP_SLVERR;
          w_nxt       = W_RESP;
        end else begin
          if (aw_hs) aw_held_nxt = 1'b1;
          if (w_hs)  w_held_nxt  = 1'b1;
          awready_nxt = !aw_held_nxt;
          wready_nxt  = !w_held_nxt;
        end
      end
      W_RESP: begin
        if (s_bvalid && s_bready) begin
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
          wready_nxt  = 1'b1;
          w_nxt       = W_IDLE;
        end
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_pulse  <= '0;
      regs      <= '0;
    end else begin
      w_state   <= w_nxt;
      aw_held   <= aw_held_nxt;
      w_held    <= w_held_nxt;
      s_awready <= awready_nxt;
      s_wready  <= wready_nxt;
      s_bvalid  <= bvalid_nxt;
      bresp_q   <= bresp_nxt;
      if (aw_hs) awaddr_q <= s_awaddr;
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      wr_pulse <= (commit && wr_ok) ? (ONE << w_idx) : '0;
      if (commit && wr_ok)
        for (int b = 0; b < SW; b++)
          if (wstb[b]) regs[w_idx][b*8 +: 8] <= wdat[b*8 +: 8];
    end
  end

  // ---------------- read channel ----------------
  rd_state_t        r_state, r_nxt;
  logic             ar_hs, arready_nxt, rvalid_nxt;
  resp_t            rresp_q;
  logic [IDX_W-1:0] r_idx;
  logic             r_inr, r_ro;

  assign ar_hs   = s_arvalid && s_arready;
  assign s_rresp = rresp_q;

  axi_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_rdec (
    .addr(s_araddr), .idx(r_idx), .in_range(r_inr), .is_ro(r_ro)
  );

  always_comb begin
    r_nxt       = r_state;
    arready_nxt = 1'b0;
    rvalid_nxt  = s_rvalid;
    case (r_state)
      R_IDLE: begin
        arready_nxt = 1'b1;
        if (ar_hs) begin
          arready_nxt = 1'b0;
          rvalid_nxt  = 1'b1;
          r_nxt       = R_DATA;
        end
      end
      R_DATA: begin
        if (s_rvalid && s_rready) begin
          rvalid_nxt  = 1'b0;
          arready_nxt = 1'b1;
          r_nxt       = R_IDLE;
        end
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  // Sampling regs here sees the pre-write value when a commit lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      rresp_q   <= RESP_OKAY;
      rd_pulse  <= '0;
    end else begin
      r_state   <= r_nxt;
      s_arready <= arready_nxt;
      s_rvalid  <= rvalid_nxt;
      rd_pulse  <= '0;
      if (ar_hs) begin
        s_rdata  <= !r_inr ? '0 : (r_ro ? hw[r_idx] : regs[r_idx]);
        rresp_q  <= r_inr ? RESP_OKAY : RESP_SLVERR;
        rd_pulse <= r_inr ? (ONE << r_idx) : '0;
      end
    end
  end

endmodule
